// File: rtl/fan_ctrl_pkg.sv
// ============================================================
// fan_ctrl_pkg : shared state/preset encodings for the fan controller
// Rev 1.0
// ============================================================
`default_nettype none

package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } fan_state_t;

    typedef enum logic [1:0] {
        TSEL_NONE = 2'd0,
        TSEL_3    = 2'd1,
        TSEL_5    = 2'd2,
        TSEL_7    = 2'd3
    } timer_sel_t;

    localparam int PRESET_MULT_3 = 3;
    localparam int PRESET_MULT_5 = 5;
    localparam int PRESET_MULT_7 = 7;

    function automatic int preset_mult(input timer_sel_t sel);
        case (sel)
            TSEL_3:  return PRESET_MULT_3;
            TSEL_5:  return PRESET_MULT_5;
            TSEL_7:  return PRESET_MULT_7;
            default: return 0;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fan_pwm_gen.sv
// ============================================================
// fan_pwm_gen : tick-driven PWM period counter with registered output
// Rev 1.0
// ============================================================
`default_nettype none

module fan_pwm_gen #(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_W     = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tick_1us,
    input  logic              i_enable,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_pwm
);

    localparam int               CNT_W    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] count;
    logic             pwm_q;

    // Counter parks at 0 while disabled so every run starts a fresh period.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= i_enable && (32'(count) < 32'(i_duty));
            if (!i_enable) begin
                count <= '0;
            end else if (i_tick_1us) begin
                count <= (count == CNT_LAST) ? '0 : count + 1'b1;
            end
        end
    end

    assign o_pwm = pwm_q;

endmodule

`default_nettype wire

// File: rtl/fan_speed_controller.sv
// ============================================================
// fan_speed_controller : speed FSM, auto-off countdown and fan PWM
// Rev 1.0
// ============================================================
`default_nettype none

module fan_speed_controller
    import fan_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 1000000,
    parameter int PWM_PERIOD     = 1000,
    parameter int DUTY_LOW       = 250,
    parameter int DUTY_MID       = 500,
    parameter int DUTY_HIGH      = 750,
    parameter int TIMER_UNIT_SEC = 60
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1us,
    input  logic       i_btn_mode,
    input  logic       i_btn_off,
    input  logic       i_btn_timer,
    output logic       o_pwm,
    output logic [1:0] o_mode,
    output logic [1:0] o_timer_sel,
    output logic       o_timer_active,
    output logic [9:0] o_remaining_sec
);

    localparam int PRESC_W  = $clog2(TICKS_PER_SEC);
    localparam int DUTY_MAX = max3(DUTY_LOW, DUTY_MID, DUTY_HIGH);
    localparam int DUTY_W   = (DUTY_MAX > 1) ? $clog2(DUTY_MAX + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    generate
        if (PRESET_MULT_7 * TIMER_UNIT_SEC >= 1024) begin : g_remaining_width_check
            $error("7 * TIMER_UNIT_SEC does not fit the 10-bit remaining counter");
        end
        if (TICKS_PER_SEC < 2) begin : g_tick_rate_check
            $error("TICKS_PER_SEC must be at least 2");
        end
    endgenerate

    fan_state_t          state, state_nxt;
    timer_sel_t          sel, sel_nxt, sel_step;
    logic                active, active_nxt;
    logic [PRESC_W-1:0]  presc, presc_nxt;
    logic [9:0]          remaining, remaining_nxt;
    logic                sec_done;
    logic                expire;
    logic [DUTY_W-1:0]   duty;

    assign sel_step = timer_sel_t'(sel + 2'd1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_OFF;
            sel       <= TSEL_NONE;
            active    <= 1'b0;
            presc     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            active    <= active_nxt;
            presc     <= presc_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Countdown runs first; expiry/off/mode/timer then override in priority order.
    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        active_nxt    = active;
        presc_nxt     = presc;
        remaining_nxt = remaining;
        sec_done      = active && i_tick_1us && (presc == PRESC_LAST);
        expire        = sec_done && (remaining == 10'd1);

        if (active && i_tick_1us) begin
            if (sec_done) begin
                presc_nxt     = '0;
                remaining_nxt = remaining - 10'd1;
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end

        if (expire || i_btn_off) begin
            state_nxt     = ST_OFF;
            sel_nxt       = TSEL_NONE;
            active_nxt    = 1'b0;
            presc_nxt     = '0;
            remaining_nxt = '0;
        end else if (i_btn_mode) begin
            case (state)
                ST_OFF:  state_nxt = ST_LOW;
                ST_LOW:  state_nxt = ST_MID;
                ST_MID:  state_nxt = ST_HIGH;
                ST_HIGH: state_nxt = ST_LOW;
                default: state_nxt = ST_LOW;
            endcase
        end else if (i_btn_timer && (state != ST_OFF)) begin
            sel_nxt       = sel_step;
            active_nxt    = (sel_step != TSEL_NONE);
            presc_nxt     = '0;
            remaining_nxt = 10'(preset_mult(sel_step) * TIMER_UNIT_SEC);
        end
    end

    always_comb begin
        duty = '0;
        case (state)
            ST_LOW:  duty = DUTY_W'(DUTY_LOW);
            ST_MID:  duty = DUTY_W'(DUTY_MID);
            ST_HIGH: duty = DUTY_W'(DUTY_HIGH);
            default: duty = '0;
        endcase
    end

    fan_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick_1us (i_tick_1us),
        .i_enable   (state != ST_OFF),
        .i_duty     (duty),
        .o_pwm      (o_pwm)
    );

    assign o_mode          = state;
    assign o_timer_sel     = sel;
    assign o_timer_active  = active;
    assign o_remaining_sec = remaining;

endmodule

`default_nettype wire

// File: tb/tb_fan_speed_controller.sv
// ============================================================
// tb_fan_speed_controller : directed + random checks against a behavioural model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fan_speed_controller;

    localparam int TPS  = 10;
    localparam int PP   = 10;
    localparam int DL   = 2;
    localparam int DM   = 5;
    localparam int DH   = 8;
    localparam int UNIT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       b_mode = 1'b0;
    logic       b_off = 1'b0;
    logic       b_timer = 1'b0;
    logic       pwm;
    logic [1:0] mode;
    logic [1:0] tsel;
    logic       active;
    logic [9:0] rem;

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;

    always #5 clk = ~clk;

    fan_speed_controller #(
        .TICKS_PER_SEC  (TPS),
        .PWM_PERIOD     (PP),
        .DUTY_LOW       (DL),
        .DUTY_MID       (DM),
        .DUTY_HIGH      (DH),
        .TIMER_UNIT_SEC (UNIT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_tick_1us      (tick),
        .i_btn_mode      (b_mode),
        .i_btn_off       (b_off),
        .i_btn_timer     (b_timer),
        .o_pwm           (pwm),
        .o_mode          (mode),
        .o_timer_sel     (tsel),
        .o_timer_active  (active),
        .o_remaining_sec (rem)
    );

    typedef struct {
        int   mode;
        int   sel;
        int   rem;
        int   presc;
        int   cnt;
        logic pwm;
    } model_t;

    model_t m;

    function automatic int duty_of(input int md);
        case (md)
            1: return DL;
            2: return DM;
            3: return DH;
            default: return 0;
        endcase
    endfunction

    function automatic int preset_secs(input int s);
        case (s)
            1: return 3 * UNIT;
            2: return 5 * UNIT;
            3: return 7 * UNIT;
            default: return 0;
        endcase
    endfunction

    // One clock of the fan's rules, written from the behavioural description.
    function automatic model_t step(input model_t s, input logic md, input logic off,
                                    input logic tm, input logic tk);
        model_t n;
        bool_expire: begin end
        n = s;
        n.pwm = (s.mode != 0) && (s.cnt < duty_of(s.mode));
        n.cnt = (s.mode == 0) ? 0 : (tk ? (s.cnt + 1) % PP : s.cnt);
        if (s.sel != 0 && tk) begin
            if (s.presc == TPS - 1) begin
                n.presc = 0;
                n.rem   = s.rem - 1;
            end else begin
                n.presc = s.presc + 1;
            end
        end
        if ((s.sel != 0 && tk && s.presc == TPS - 1 && s.rem == 1) || off) begin
            n.mode = 0; n.sel = 0; n.rem = 0; n.presc = 0;
        end else if (md) begin
            n.mode = (s.mode == 3) ? 1 : s.mode + 1;
        end else if (tm && s.mode != 0) begin
            n.sel   = (s.sel + 1) % 4;
            n.rem   = preset_secs(n.sel);
            n.presc = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else     m <= step(m, b_mode, b_off, b_timer, tick);
    end

    task automatic drive_cycle(input logic md, input logic off, input logic tm);
        @(negedge clk);
        tick_cnt++;
        tick    = (tick_cnt % 4 == 0);
        b_mode  = md;
        b_off   = off;
        b_timer = tm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) drive_cycle(0, 0, 0);
        total++; if (pwm !== 1'b0)   begin bad++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
        total++; if (mode !== 2'd0)  begin bad++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        total++; if (tsel !== 2'd0)  begin bad++; $display("FAIL reset_sel: got %0d expected 0", tsel); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b expected 0", active); end
        total++; if (rem !== 10'd0)  begin bad++; $display("FAIL reset_rem: got %0d expected 0", rem); end
        rst = 1'b0;
        drive_cycle(0, 0, 0);
    endtask

    task automatic test_mode_cycle();
        int exp_seq [4];
        int exp_hi  [3];
        int hi;
        exp_seq = '{1, 2, 3, 1};
        exp_hi  = '{DL * 4, DM * 4, DH * 4};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 0, 0);
            drive_cycle(0, 0, 0);
            total++;
            if (mode !== 2'(exp_seq[i])) begin
                bad++; $display("FAIL mode_step%0d: got %0d expected %0d", i, mode, exp_seq[i]);
            end
            if (i < 3) begin
                hi = 0;
                repeat (2) drive_cycle(0, 0, 0);
                repeat (40) begin
                    drive_cycle(0, 0, 0);
                    if (pwm === 1'b1) hi++;
                end
                total++;
                if (hi != exp_hi[i]) begin
                    bad++; $display("FAIL pwm_duty_mode%0d: got %0d high cycles expected %0d", exp_seq[i], hi, exp_hi[i]);
                end
            end
        end
    endtask

    task automatic test_timer_countdown();
        int prev;
        int last_dec;
        int decs;
        bit done;
        drive_cycle(1, 0, 0);
        drive_cycle(0, 0, 1);
        drive_cycle(0, 0, 0);
        total++; if (mode !== 2'd2)  begin bad++; $display("FAIL cd_mode: got %0d expected 2", mode); end
        total++; if (tsel !== 2'd1)  begin bad++; $display("FAIL cd_sel: got %0d expected 1", tsel); end
        total++; if (rem !== 10'd3)  begin bad++; $display("FAIL cd_rem: got %0d expected 3", rem); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL cd_active: got %b expected 1", active); end
        prev = 3; last_dec = 0; decs = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            drive_cycle(0, 0, 0);
            if (int'(rem) != prev) begin
                total++;
                if (int'(rem) != prev - 1) begin
                    bad++; $display("FAIL cd_dec_value: got %0d expected %0d", rem, prev - 1);
                end
                if (decs > 0) begin
                    total++;
                    if (c - last_dec != 40) begin
                        bad++; $display("FAIL cd_interval: got %0d cycles expected 40", c - last_dec);
                    end
                end
                last_dec = c; decs++; prev = int'(rem);
                if (rem == 10'd0) begin
                    done = 1;
                    total++; if (mode !== 2'd0)  begin bad++; $display("FAIL cd_expire_mode: got %0d expected 0", mode); end
                    total++; if (tsel !== 2'd0)  begin bad++; $display("FAIL cd_expire_sel: got %0d expected 0", tsel); end
                    total++; if (active !== 1'b0) begin bad++; $display("FAIL cd_expire_active: got %b expected 0", active); end
                end
            end
        end
        if (!done) begin
            total++; bad++; $display("FAIL cd_timeout: got rem %0d expected 0 within 400 cycles", rem);
        end
        drive_cycle(0, 0, 0);
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL cd_expire_pwm: got %b expected 0", pwm); end
    endtask

    task automatic test_off_priority();
        drive_cycle(0, 0, 1);
        drive_cycle(0, 0, 0);
        total++; if (tsel !== 2'd0)  begin bad++; $display("FAIL off_timer_sel: got %0d expected 0", tsel); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL off_timer_active: got %b expected 0", active); end
        drive_cycle(1, 1, 0);
        drive_cycle(0, 0, 0);
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL off_beats_mode: got %0d expected 0", mode); end
        drive_cycle(1, 0, 1);
        drive_cycle(0, 0, 0);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL mode_beats_timer_mode: got %0d expected 1", mode); end
        total++; if (tsel !== 2'd0) begin bad++; $display("FAIL mode_beats_timer_sel: got %0d expected 0", tsel); end
    endtask

    task automatic test_expiry_priority();
        bit found;
        drive_cycle(0, 0, 1);
        drive_cycle(0, 0, 0);
        total++; if (rem !== 10'd3) begin bad++; $display("FAIL exp_load: got %0d expected 3", rem); end
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (m.rem == 1 && m.presc == TPS - 1 && ((tick_cnt + 1) % 4 == 0)) found = 1;
            else drive_cycle(0, 0, 0);
        end
        if (!found) begin
            total++; bad++; $display("FAIL exp_timeout: got rem %0d expected expiry window within 300 cycles", rem);
        end else begin
            total++; if (rem !== 10'd1) begin bad++; $display("FAIL exp_pre_rem: got %0d expected 1", rem); end
            drive_cycle(1, 0, 0);
            drive_cycle(0, 0, 0);
            total++; if (mode !== 2'd0)  begin bad++; $display("FAIL exp_beats_mode: got %0d expected 0", mode); end
            total++; if (tsel !== 2'd0)  begin bad++; $display("FAIL exp_sel: got %0d expected 0", tsel); end
            total++; if (active !== 1'b0) begin bad++; $display("FAIL exp_active: got %b expected 0", active); end
            total++; if (rem !== 10'd0)  begin bad++; $display("FAIL exp_rem: got %0d expected 0", rem); end
        end
    endtask

    task automatic test_reset_midrun();
        int hi;
        repeat (3) begin drive_cycle(1, 0, 0); drive_cycle(0, 0, 0); end
        repeat (3) begin drive_cycle(0, 0, 1); drive_cycle(0, 0, 0); end
        total++; if (mode !== 2'd3) begin bad++; $display("FAIL mr_mode: got %0d expected 3", mode); end
        total++; if (tsel !== 2'd3) begin bad++; $display("FAIL mr_sel: got %0d expected 3", tsel); end
        total++; if (rem !== 10'd7) begin bad++; $display("FAIL mr_rem: got %0d expected 7", rem); end
        repeat (17) drive_cycle(0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (pwm !== 1'b0)   begin bad++; $display("FAIL mr_async_pwm: got %b expected 0", pwm); end
        total++; if (mode !== 2'd0)  begin bad++; $display("FAIL mr_async_mode: got %0d expected 0", mode); end
        total++; if (tsel !== 2'd0)  begin bad++; $display("FAIL mr_async_sel: got %0d expected 0", tsel); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL mr_async_active: got %b expected 0", active); end
        total++; if (rem !== 10'd0)  begin bad++; $display("FAIL mr_async_rem: got %0d expected 0", rem); end
        drive_cycle(0, 0, 0);
        rst = 1'b0;
        drive_cycle(1, 0, 0);
        drive_cycle(0, 0, 0);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL mr_after_mode: got %0d expected 1", mode); end
        total++; if (tsel !== 2'd0) begin bad++; $display("FAIL mr_after_sel: got %0d expected 0", tsel); end
        drive_cycle(0, 0, 0);
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL mr_pwm_restart: got %b expected 1", pwm); end
        hi = (pwm === 1'b1) ? 1 : 0;
        repeat (39) begin
            drive_cycle(0, 0, 0);
            if (pwm === 1'b1) hi++;
            total++;
            if (pwm !== m.pwm) begin bad++; $display("FAIL mr_pwm_model: got %b expected %b", pwm, m.pwm); end
        end
        total++; if (hi != DL * 4) begin bad++; $display("FAIL mr_first_period: got %0d high cycles expected %0d", hi, DL * 4); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            drive_cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 59) == 0),
                        ($urandom_range(0, 9) == 0));
            total++; if (pwm !== m.pwm) begin bad++; $display("FAIL rnd_pwm c%0d: got %b expected %b", c, pwm, m.pwm); end
            total++; if (int'(mode) != m.mode) begin bad++; $display("FAIL rnd_mode c%0d: got %0d expected %0d", c, mode, m.mode); end
            total++; if (int'(tsel) != m.sel) begin bad++; $display("FAIL rnd_sel c%0d: got %0d expected %0d", c, tsel, m.sel); end
            total++; if (active !== (m.sel != 0)) begin bad++; $display("FAIL rnd_active c%0d: got %b expected %b", c, active, (m.sel != 0)); end
            total++; if (int'(rem) != m.rem) begin bad++; $display("FAIL rnd_rem c%0d: got %0d expected %0d", c, rem, m.rem); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mode_cycle();
        test_timer_countdown();
        test_off_priority();
        test_expiry_priority();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
